hilo_acc_reg: RTL and testbench

HILO_ACC_REG -- requirements
Module: hilo_acc_reg

---
 rtl/hilo_acc_reg.sv | 104 ++++++++++
 tb/tb_hilo_acc_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_acc_reg.sv
// HI/LO result register for a mul/div unit: holds a 2W-bit result, optionally
// accumulates successive results, and serves registered HI/LO reads and direct writes.
module hilo_acc_reg #(
    parameter int W      = 32,
    parameter bit ACC_EN = 1'b1
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic           res_valid,
    input  logic [2*W-1:0] res_data,
    input  logic           res_err,
    input  logic           mthi_en,
    input  logic           mtlo_en,
    input  logic [W-1:0]   wr_data,
    input  logic           rd_hi_en,
    input  logic           rd_lo_en,
    input  logic           err_clr,
    output logic [W-1:0]   HI,
    output logic [W-1:0]   LO,
    output logic           busy,
    output logic           stall,
    output logic           err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;
    localparam logic [1:0] M_LOAD = 2'b00;
    localparam logic [1:0] M_ADD  = 2'b01;
    localparam logic [1:0] M_SUB  = 2'b10;

    logic [0:0]     state;
    logic [1:0]     op_mode;
    logic [2*W-1:0] data;
    logic [2*W-1:0] data_next;
    logic           done;

    // Modulo-2^(2W) combine of the held value with a new result; mode 11 loads.
    function automatic logic [2*W-1:0] apply_op(input logic [1:0]     op,
                                                input logic [2*W-1:0] cur,
                                                input logic [2*W-1:0] res);
        logic [2*W-1:0] r;
        r = res;
        if (ACC_EN) begin
            case (op)
                M_ADD:   r = cur + res;
                M_SUB:   r = cur - res;
                default: r = res;
            endcase
        end
        return r;
    endfunction

    assign busy  = (state == S_PEND);
    assign stall = busy & (rd_hi_en | rd_lo_en | mthi_en | mtlo_en);
    assign done  = busy & res_valid;

    // Reads see the post-edge value, so a same-cycle mthi/mtlo is forwarded.
    always_comb begin
        data_next = data;
        if (done && !res_err) begin
            data_next = apply_op(op_mode, data, res_data);
        end else if (!busy) begin
            if (mthi_en) data_next[2*W-1:W] = wr_data;
            if (mtlo_en) data_next[W-1:0]   = wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= S_IDLE;
            op_mode <= M_LOAD;
            data    <= '0;
            HI      <= '0;
            LO      <= '0;
            err     <= 1'b0;
        end else begin
            data <= data_next;

            if (!busy && rd_hi_en) HI <= data_next[2*W-1:W];
            if (!busy && rd_lo_en) LO <= data_next[W-1:0];

            if (done && res_err) err <= 1'b1;
            else if (err_clr)    err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_PEND;
                        op_mode <= mode;
                    end
                end
                default: begin
                    if (res_valid) begin
                        if (start) op_mode <= mode;
                        else       state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Bench for hilo_acc_reg: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the HI/LO register.
module tb_hilo_acc_reg;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr_n;
    logic           start;
    logic [1:0]     mode;
    logic           res_valid;
    logic [2*W-1:0] res_data;
    logic           res_err;
    logic           mthi_en;
    logic           mtlo_en;
    logic [W-1:0]   wr_data;
    logic           rd_hi_en;
    logic           rd_lo_en;
    logic           err_clr;
    logic [W-1:0]   HI;
    logic [W-1:0]   LO;
    logic           busy;
    logic           stall;
    logic           err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] m_data;
    logic        m_pend;
    logic [1:0]  m_mode;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        m_err;

    hilo_acc_reg #(.W(W), .ACC_EN(1'b1)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .mode(mode),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wr_data(wr_data),
        .rd_hi_en(rd_hi_en), .rd_lo_en(rd_lo_en), .err_clr(err_clr),
        .HI(HI), .LO(LO), .busy(busy), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 0; mode = 0; res_valid = 0; res_data = '0; res_err = 0;
        mthi_en = 0; mtlo_en = 0; wr_data = '0; rd_hi_en = 0; rd_lo_en = 0; err_clr = 0;
    endtask

    task automatic model_reset();
        m_data = '0; m_pend = 0; m_mode = 0; m_hi = '0; m_lo = '0; m_err = 0;
    endtask

    // One clock: check stall before the edge, advance the model, check outputs after.
    task automatic step();
        logic was_pend;
        #2;
        check("stall", stall, m_pend & (rd_hi_en | rd_lo_en | mthi_en | mtlo_en));
        @(posedge clk);
        was_pend = m_pend;
        if (was_pend && res_valid) begin
            if (res_err) m_err = 1;
            else if (m_mode == 2'd1) m_data = m_data + res_data;
            else if (m_mode == 2'd2) m_data = m_data - res_data;
            else m_data = res_data;
        end
        if (!(was_pend && res_valid && res_err) && err_clr) m_err = 0;
        if (!was_pend) begin
            if (mthi_en) m_data[63:32] = wr_data;
            if (mtlo_en) m_data[31:0]  = wr_data;
            if (rd_hi_en) m_hi = m_data[63:32];
            if (rd_lo_en) m_lo = m_data[31:0];
            if (start) begin m_pend = 1; m_mode = mode; end
        end else if (res_valid) begin
            if (start) m_mode = mode;
            else m_pend = 0;
        end
        #1;
        check("HI", HI, m_hi);
        check("LO", LO, m_lo);
        check("busy", busy, m_pend);
        check("err", err, m_err);
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        clr_n = 0;
        #1;
        model_reset();
        check("rst_HI", HI, 0);
        check("rst_LO", LO, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        #3 clr_n = 1;
    endtask

    task automatic issue(input logic [1:0] md);
        start = 1; mode = md; step();
    endtask

    task automatic result(input logic [63:0] d, input logic e);
        res_valid = 1; res_data = d; res_err = e; step();
    endtask

    task automatic read_both();
        rd_hi_en = 1; rd_lo_en = 1; step();
    endtask

    initial begin
        idle_inputs();
        clr_n = 1;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Plain load after a few wait cycles
        issue(2'b00);
        step(); step();
        result(64'h0000_0005_0000_0007, 0);
        check("load_busy", busy, 0);
        read_both();
        check("load_HI", HI, 32'h5);
        check("load_LO", LO, 32'h7);

        // Wrapping add and subtract
        mthi_en = 1; mtlo_en = 1; wr_data = 32'hFFFF_FFFF; step();
        issue(2'b01); result(64'h2, 0); read_both();
        check("add_HI", HI, 32'h0);
        check("add_LO", LO, 32'h1);
        issue(2'b10); result(64'h3, 0); read_both();
        check("sub_HI", HI, 32'hFFFF_FFFF);
        check("sub_LO", LO, 32'hFFFF_FFFE);

        // Requests while busy are stalled and then honoured
        issue(2'b00);
        rd_lo_en = 1; mthi_en = 1; wr_data = 32'hA5A5_0001;
        #2 check("stall_busy", stall, 1);
        step();
        check("stall_LO_held", LO, 32'hFFFF_FFFE);
        res_valid = 1; res_data = 64'h1111_2222_3333_4444;
        rd_lo_en = 1; mthi_en = 1; wr_data = 32'hA5A5_0001; step();
        rd_lo_en = 1; mthi_en = 1; wr_data = 32'hA5A5_0001;
        #2 check("stall_idle", stall, 0);
        step();
        check("stall_after_LO", LO, 32'h3333_4444);
        rd_hi_en = 1; step();
        check("stall_after_HI", HI, 32'hA5A5_0001);

        // Error handling and err_clr priority
        issue(2'b01); result(64'h1234, 1);
        check("err_set", err, 1);
        read_both();
        check("err_data_LO", LO, 32'h3333_4444);
        issue(2'b00);
        res_valid = 1; res_err = 1; err_clr = 1; step();
        check("err_set_wins", err, 1);
        err_clr = 1; step();
        check("err_cleared", err, 0);

        // Back-to-back issue on completion
        issue(2'b00);
        res_valid = 1; res_data = 64'h10; start = 1; mode = 2'b01; step();
        check("b2b_busy", busy, 1);
        result(64'h20, 0);
        read_both();
        check("b2b_LO", LO, 32'h30);

        // Reset mid-operation abandons it
        issue(2'b00);
        @(negedge clk);
        do_reset();
        result(64'h99, 0);
        read_both();
        check("rst_ign_LO", LO, 0);
        check("rst_ign_HI", HI, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 99) < 30);
            mode      = 2'($urandom);
            res_valid = ($urandom_range(0, 99) < 35);
            res_err   = ($urandom_range(0, 99) < 10);
            res_data  = {$urandom, $urandom};
            mthi_en   = ($urandom_range(0, 99) < 20);
            mtlo_en   = ($urandom_range(0, 99) < 20);
            wr_data   = $urandom;
            rd_hi_en  = ($urandom_range(0, 99) < 35);
            rd_lo_en  = ($urandom_range(0, 99) < 35);
            err_clr   = ($urandom_range(0, 99) < 10);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
